// File: rtl/data_mem_port_pkg.sv
// data_mem_port_pkg: access-size and FSM types plus lane/extend helpers for the load/store port
package data_mem_port_pkg;
  typedef enum logic [1:0] {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10} acc_size_e;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_e;
  function automatic logic misaligned(acc_size_e s, logic [1:0] off);
    return (s == HALF) ? off[0] : (s == WORD) ? |off : 1'b0;
  endfunction
  function automatic logic [3:0] byte_en(acc_size_e s, logic [1:0] off);
    return (s == WORD) ? 4'b1111 : (s == HALF) ? 4'b0011 << off : 4'b0001 << off;
  endfunction
  function automatic logic [31:0] lane_rep(acc_size_e s, logic [31:0] d);
    return (s == WORD) ? d : (s == HALF) ? {2{d[15:0]}} : {4{d[7:0]}};
  endfunction
  function automatic logic [31:0] extend(acc_size_e s, logic uns, logic [31:0] d);
    return (s == WORD) ? d :
           (s == HALF) ? {{16{~uns & d[15]}}, d[15:0]} : {{24{~uns & d[7]}}, d[7:0]};
  endfunction
endpackage

// File: rtl/data_mem_port_load_align.sv
// data_mem_port_load_align: shifts the addressed lane of a memory word down and sign/zero-extends it
module data_mem_port_load_align
  import data_mem_port_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  off,
  input  acc_size_e   size,
  input  logic        uns,
  output logic [31:0] data
);
  assign data = extend(size, uns, mem_rdata >> {off, 3'b000});
endmodule

// File: rtl/data_mem_port.sv
// data_mem_port: turns core load/store requests into byte-enabled word accesses to a latency-RD_LAT memory
module data_mem_port
  import data_mem_port_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              wdone,
  output logic              err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  state_e state_q, state_d;
  acc_size_e size_q, size_d, size_in;
  logic we_q, we_d, uns_q, uns_d;
  logic rvalid_q, rvalid_d, wdone_q, wdone_d, err_q, err_d;
  logic [1:0] off_q, off_d;
  logic [2:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d, rdata_q, rdata_d, load_data;
  logic unused_addr;
  assign size_in = acc_size_e'(size);
  assign unused_addr = ^addr[31:ADDR_W+2];
  data_mem_port_load_align u_align (
    .mem_rdata(mem_rdata),
    .off(off_q),
    .size(size_q),
    .uns(uns_q),
    .data(load_data)
  );
  always_comb begin
    state_d = state_q;
    size_d = size_q;
    we_d = we_q;
    uns_d = uns_q;
    off_d = off_q;
    cnt_d = cnt_q;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d = rdata_q;
    rvalid_d = 1'b0;
    wdone_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        if (misaligned(size_in, addr[1:0])) err_d = 1'b1;
        else begin
          state_d = ACCESS;
          we_d = we;
          size_d = size_in;
          uns_d = uns;
          off_d = addr[1:0];
          mem_addr_d = addr[ADDR_W+1:2];
          mem_wdata_d = lane_rep(size_in, wdata);
        end
      end
      ACCESS: begin
        state_d = we_q ? IDLE : WAIT;
        wdone_d = we_q;
        cnt_d = we_q ? cnt_q : 3'(RD_LAT);
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = IDLE;
          rvalid_d = 1'b1;
          rdata_d = load_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      size_q <= BYTE;
      we_q <= 1'b0;
      uns_q <= 1'b0;
      off_q <= 2'b00;
      cnt_q <= 3'd0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      rdata_q <= '0;
      rvalid_q <= 1'b0;
      wdone_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q <= size_d;
      we_q <= we_d;
      uns_q <= uns_d;
      off_q <= off_d;
      cnt_q <= cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q <= rdata_d;
      rvalid_q <= rvalid_d;
      wdone_q <= wdone_d;
      err_q <= err_d;
    end
  end
  assign busy = state_q != IDLE;
  assign mem_en = state_q == ACCESS;
  assign mem_we = mem_en & we_q;
  assign mem_be = mem_en ? byte_en(size_q, off_q) : 4'b0000;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata = rdata_q;
  assign rvalid = rvalid_q;
  assign wdone = wdone_q;
  assign err = err_q;
endmodule

// File: tb/tb_data_mem_port.sv
// tb_data_mem_port: table-driven scoreboard bench for data_mem_port at read latencies 1 and 3
module tb_data_mem_port;
  import data_mem_port_pkg::*;
  typedef struct {
    logic we; logic [1:0] size; logic uns; logic [31:0] addr; logic [31:0] wdata;
    logic e_err; logic [3:0] e_be; logic [9:0] e_maddr; logic [31:0] e_wdata; logic [31:0] e_rdata;
  } vec_t;
  typedef struct {int due; logic [2:0] kind; logic [31:0] data;} exp_t;
  typedef struct {int due; logic we; logic [3:0] be; logic [9:0] maddr; logic [31:0] wd;} acc_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst [2], req [2], we [2], uns [2];
  logic [1:0] size [2];
  logic [31:0] addr [2], wdata [2];
  logic busy [2], rvalid [2], wdone [2], err [2], mem_en [2], mem_we [2];
  logic [31:0] rdata [2], mem_wdata [2], mem_rdata [2];
  logic [3:0] mem_be [2];
  logic [9:0] mem_addr [2];
  int cyc = 0, errors = 0, checks = 0;
  int bs [2], bend [2];
  exp_t sq [2][$];
  acc_t aq [2][$];
  exp_t me;
  acc_t ma;
  logic [2:0] mp;
  vec_t tv [$];
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = g ? 3 : 1;
    logic [31:0] mem [1024];
    logic [31:0] pipe [7];
    logic [6:0] pv = '0;
    data_mem_port #(.ADDR_W(10), .RD_LAT(L)) u_dut (
      .clk(clk), .rst(rst[g]), .req(req[g]), .we(we[g]), .size(size[g]), .uns(uns[g]),
      .addr(addr[g]), .wdata(wdata[g]), .busy(busy[g]), .rdata(rdata[g]), .rvalid(rvalid[g]),
      .wdone(wdone[g]), .err(err[g]), .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_be(mem_be[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
    );
    always @(posedge clk) begin
      if (mem_en[g] && mem_we[g])
        for (int b = 0; b < 4; b++) if (mem_be[g][b]) mem[mem_addr[g]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
      pv <= {pv[5:0], mem_en[g] && !mem_we[g]};
      pipe[0] <= mem[mem_addr[g]];
      for (int k = 1; k < 7; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rdata[g] = pv[L-1] ? pipe[L-1] : 32'hDEAD_0BAD;
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %h expected %h", n, cyc, act, exp);
    end
  endtask
  function automatic int lat(input int i);
    return i ? 3 : 1;
  endfunction
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) continue;
      while (sq[i].size() > 0 && sq[i][0].due < cyc) begin
        chk("missed_pulse", 32'(cyc), 32'(sq[i][0].due));
        void'(sq[i].pop_front());
      end
      while (aq[i].size() > 0 && aq[i][0].due < cyc) begin
        chk("missed_mem_en", 32'(cyc), 32'(aq[i][0].due));
        void'(aq[i].pop_front());
      end
      mp = {rvalid[i], wdone[i], err[i]};
      if (mp != 3'b000) begin
        if (sq[i].size() == 0) chk("spurious_pulse", 32'(mp), 32'd0);
        else begin
          me = sq[i].pop_front();
          chk("pulse_cycle", 32'(cyc), 32'(me.due));
          chk("pulse_kind", 32'(mp), 32'(me.kind));
          if (me.kind == 3'b100) chk("rdata", rdata[i], me.data);
        end
      end
      if (mem_en[i]) begin
        if (aq[i].size() == 0) chk("spurious_mem_en", 32'(mem_en[i]), 32'd0);
        else begin
          ma = aq[i].pop_front();
          chk("mem_en_cycle", 32'(cyc), 32'(ma.due));
          chk("mem_we", 32'(mem_we[i]), 32'(ma.we));
          chk("mem_be", 32'(mem_be[i]), 32'(ma.be));
          chk("mem_addr", 32'(mem_addr[i]), 32'(ma.maddr));
          if (ma.we) chk("mem_wdata", mem_wdata[i], ma.wd);
        end
      end else begin
        chk("idle_be", 32'(mem_be[i]), 32'd0);
        chk("idle_we", 32'(mem_we[i]), 32'd0);
      end
      chk("busy", 32'(busy[i]), 32'(cyc >= bs[i] && cyc <= bend[i]));
    end
  end
  task automatic issue(input int i, input vec_t v);
    int t, n;
    n = 0;
    while (busy[i] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("issue_wait_busy", 32'(busy[i]), 32'd0);
    t = cyc;
    req[i] = 1'b1; we[i] = v.we; size[i] = v.size; uns[i] = v.uns; addr[i] = v.addr; wdata[i] = v.wdata;
    if (v.e_err) begin
      sq[i].push_back('{t + 1, 3'b001, 32'h0});
      bs[i] = t + 1; bend[i] = t;
    end else begin
      aq[i].push_back('{t + 1, v.we, v.e_be, v.e_maddr, v.e_wdata});
      sq[i].push_back('{v.we ? t + 2 : t + 2 + lat(i), v.we ? 3'b010 : 3'b100, v.e_rdata});
      bs[i] = t + 1; bend[i] = v.we ? t + 1 : t + 1 + lat(i);
    end
    @(posedge clk); #1;
    req[i] = 1'b0;
  endtask
  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; req[i] = 1'b0; we[i] = 1'b0; size[i] = 2'b00; uns[i] = 1'b0;
      addr[i] = '0; wdata[i] = '0; bs[i] = 1; bend[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", 32'(busy[i]), 32'd0);
      chk("rst_rvalid", 32'(rvalid[i]), 32'd0);
      chk("rst_wdone", 32'(wdone[i]), 32'd0);
      chk("rst_err", 32'(err[i]), 32'd0);
      chk("rst_mem_en", 32'(mem_en[i]), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr[i]), 32'd0);
      chk("rst_mem_wdata", mem_wdata[i], 32'd0);
      chk("rst_rdata", rdata[i], 32'd0);
    end
    tv.push_back('{1, WORD, 0, 32'h0000_0100, 32'h0012_3456, 0, 4'b1111, 10'h040, 32'h0012_3456, 32'h0});
    tv.push_back('{1, BYTE, 0, 32'h0000_0103, 32'h0000_00A5, 0, 4'b1000, 10'h040, 32'hA5A5_A5A5, 32'h0});
    tv.push_back('{0, BYTE, 0, 32'h0000_0103, 32'h0, 0, 4'b1000, 10'h040, 32'h0, 32'hFFFF_FFA5});
    tv.push_back('{0, BYTE, 1, 32'h0000_0103, 32'h0, 0, 4'b1000, 10'h040, 32'h0, 32'h0000_00A5});
    tv.push_back('{1, WORD, 0, 32'h0000_0100, 32'h8001_1234, 0, 4'b1111, 10'h040, 32'h8001_1234, 32'h0});
    tv.push_back('{0, HALF, 0, 32'h0000_0102, 32'h0, 0, 4'b1100, 10'h040, 32'h0, 32'hFFFF_8001});
    tv.push_back('{0, HALF, 1, 32'h0000_0102, 32'h0, 0, 4'b1100, 10'h040, 32'h0, 32'h0000_8001});
    tv.push_back('{0, WORD, 0, 32'h0000_0100, 32'h0, 0, 4'b1111, 10'h040, 32'h0, 32'h8001_1234});
    tv.push_back('{0, WORD, 0, 32'h0000_0002, 32'h0, 1, 4'b0000, 10'h000, 32'h0, 32'h0});
    tv.push_back('{0, HALF, 0, 32'h0000_0101, 32'h0, 1, 4'b0000, 10'h000, 32'h0, 32'h0});
    tv.push_back('{1, HALF, 0, 32'h0000_0003, 32'h1111, 1, 4'b0000, 10'h000, 32'h0, 32'h0});
    tv.push_back('{1, WORD, 0, 32'h0000_0104, 32'h0, 0, 4'b1111, 10'h041, 32'h0, 32'h0});
    tv.push_back('{1, HALF, 0, 32'h0000_0106, 32'h1234_BEEF, 0, 4'b1100, 10'h041, 32'hBEEF_BEEF, 32'h0});
    tv.push_back('{0, HALF, 0, 32'h0000_0106, 32'h0, 0, 4'b1100, 10'h041, 32'h0, 32'hFFFF_BEEF});
    tv.push_back('{0, BYTE, 0, 32'h0000_0107, 32'h0, 0, 4'b1000, 10'h041, 32'h0, 32'hFFFF_FFBE});
    tv.push_back('{0, BYTE, 1, 32'h0000_0105, 32'h0, 0, 4'b0010, 10'h041, 32'h0, 32'h0000_0000});
    tv.push_back('{0, WORD, 0, 32'h0000_0104, 32'h0, 0, 4'b1111, 10'h041, 32'h0, 32'hBEEF_0000});
    tv.push_back('{0, BYTE, 0, 32'h0000_0101, 32'h0, 0, 4'b0010, 10'h040, 32'h0, 32'h0000_0012});
    tv.push_back('{0, WORD, 0, 32'hFFFF_F100, 32'h0, 0, 4'b1111, 10'h040, 32'h0, 32'h8001_1234});
    tv.push_back('{1, BYTE, 0, 32'h0000_0100, 32'hFFFF_FF7F, 0, 4'b0001, 10'h040, 32'h7F7F_7F7F, 32'h0});
    tv.push_back('{0, BYTE, 0, 32'h0000_0100, 32'h0, 0, 4'b0001, 10'h040, 32'h0, 32'h0000_007F});
    tv.push_back('{0, HALF, 0, 32'h0000_0100, 32'h0, 0, 4'b0011, 10'h040, 32'h0, 32'h0000_127F});
    foreach (tv[k]) issue(0, tv[k]);
    issue(1, '{1, WORD, 0, 32'h8, 32'h1357_9BDF, 0, 4'b1111, 10'h002, 32'h1357_9BDF, 32'h0});
    issue(1, '{0, WORD, 0, 32'h8, 32'h0, 0, 4'b1111, 10'h002, 32'h0, 32'h1357_9BDF});
    issue(1, '{0, WORD, 0, 32'h8, 32'h0, 0, 4'b1111, 10'h002, 32'h0, 32'h1357_9BDF});
    repeat (2) begin @(posedge clk); #1; end
    rst[1] = 1'b1;
    sq[1].delete(); aq[1].delete();
    bs[1] = 1; bend[1] = 0;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    chk("midrst_busy", 32'(busy[1]), 32'd0);
    chk("midrst_mem_en", 32'(mem_en[1]), 32'd0);
    chk("midrst_rvalid", 32'(rvalid[1]), 32'd0);
    chk("midrst_rdata", rdata[1], 32'd0);
    repeat (8) begin @(posedge clk); #1; end
    issue(1, '{1, WORD, 0, 32'h10, 32'hDEAD_BEEF, 0, 4'b1111, 10'h004, 32'hDEAD_BEEF, 32'h0});
    issue(1, '{0, WORD, 0, 32'h10, 32'h0, 0, 4'b1111, 10'h004, 32'h0, 32'hDEAD_BEEF});
    n = 0;
    while ((sq[0].size() + sq[1].size() + aq[0].size() + aq[1].size()) > 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 32'(sq[0].size() + sq[1].size() + aq[0].size() + aq[1].size()), 32'd0);
    repeat (5) begin @(posedge clk); #1; end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
